// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite responder exposing NUM_REGS 32-bit R/W registers, mirrored in parallel on regs_o.
// Ports: clk_i/rst_i (sync active-high); AW/W/B write channels; AR/R read channels; regs_o (reg k at [k*32 +: 32]).
// Optional macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR (2'b10) instead of OKAY.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr_i,
  input  logic                           s_awvalid_i,
  output logic                           s_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb_i,
  input  logic                           s_wvalid_i,
  output logic                           s_wready_o,
  output logic [1:0]                     s_bresp_o,
  output logic                           s_bvalid_o,
  input  logic                           s_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_araddr_i,
  input  logic                           s_arvalid_i,
  output logic                           s_arready_o,
  output logic [DATA_WIDTH-1:0]          s_rdata_o,
  output logic [1:0]                     s_rresp_o,
  output logic                           s_rvalid_o,
  input  logic                           s_rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NREGS = ADDR_WIDTH'(NUM_REGS);
  localparam logic [0:0] WR_IDLE = 1'b0, WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0, RD_DATA = 1'b1;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [0:0]              r_wr_state;
  logic                    r_awready, r_wready, r_bvalid;
  logic [1:0]              r_bresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [0:0]              r_rd_state;
  logic                    r_arready, r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   w_aw_idx, w_ar_idx;
  logic                    w_aw_hit, w_ar_hit, w_commit;
  assign w_aw_idx = (r_awaddr - BASE_ADDR) >> 2;
  assign w_ar_idx = (s_araddr_i - BASE_ADDR) >> 2;
  assign w_aw_hit = r_awaddr >= BASE_ADDR && w_aw_idx < NREGS;
  assign w_ar_hit = s_araddr_i >= BASE_ADDR && w_ar_idx < NREGS;
  // A dropped ready means that half of the write has been latched.
  assign w_commit = r_wr_state == WR_IDLE && !r_awready && !r_wready;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      if (r_awready && s_awvalid_i) begin
        r_awaddr  <= s_awaddr_i;
        r_awready <= 1'b0;
      end
      if (r_wready && s_wvalid_i) begin
        r_wdata  <= s_wdata_i;
        r_wstrb  <= s_wstrb_i;
        r_wready <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid   <= 1'b1;
        r_bresp    <= w_aw_hit ? 2'b00 : RESP_OOR;
        r_wr_state <= WR_RESP;
      end
      if (r_wr_state == WR_RESP && s_bready_i) begin
        r_bvalid   <= 1'b0;
        r_awready  <= 1'b1;
        r_wready   <= 1'b1;
        r_wr_state <= WR_IDLE;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else if (w_commit && w_aw_hit) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (r_wstrb[b]) r_regs[w_aw_idx[IW-1:0]][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end
  end
  // Capture uses the pre-edge array, so a same-edge write is not yet visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
    end else if (r_rd_state == RD_IDLE && r_arready && s_arvalid_i) begin
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b1;
      r_rdata    <= w_ar_hit ? r_regs[w_ar_idx[IW-1:0]] : '0;
      r_rresp    <= w_ar_hit ? 2'b00 : RESP_OOR;
      r_rd_state <= RD_DATA;
    end else if (r_rd_state == RD_DATA && s_rready_i) begin
      r_rvalid   <= 1'b0;
      r_arready  <= 1'b1;
      r_rd_state <= RD_IDLE;
    end
  end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
  end
  assign s_awready_o = r_awready;
  assign s_wready_o  = r_wready;
  assign s_bvalid_o  = r_bvalid;
  assign s_bresp_o   = r_bresp;
  assign s_arready_o = r_arready;
  assign s_rvalid_o  = r_rvalid;
  assign s_rdata_o   = r_rdata;
  assign s_rresp_o   = r_rresp;
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: randomized AXI4-Lite traffic against an array-based register model.
module tb_axil_reg_slave;
  localparam int NR = 16;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif
  logic clk = 1'b0, rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [NR*32-1:0] regs_o;
  logic [31:0] m_regs [NR];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  axil_reg_slave #(.NUM_REGS(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
    .regs_o(regs_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit m_hit(input logic [31:0] a);
    return a[31:2] < 30'(NR);
  endfunction
  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return m_hit(a) ? m_regs[a[5:2]] : 32'h0;
  endfunction
  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_hit(a) ? 2'b00 : OOR;
  endfunction
  task automatic m_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m_hit(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_all_regs(input string tag);
    for (int k = 0; k < NR; k++) check(tag, regs_o[k*32 +: 32], m_regs[k]);
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_d, input int w_d, input int b_d);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_d;
      wvalid  = !w_done && cyc >= w_d;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      check("wr_hs_timeout", 0, 1);
      return;
    end
    check("b_early", bvalid, 0);
    tick();
    check("b_latency", bvalid, 1);
    m_wr(a, d, s);
    for (int k = 0; k < b_d; k++) begin
      check("b_hold", {bresp, bvalid}, {m_resp(a), 1'b1});
      check("aw_w_blocked", {awready, wready}, 0);
      awvalid = 1;
      tick();
    end
    awvalid = 0;
    check("bresp", bresp, m_resp(a));
    check("bvalid", bvalid, 1);
    bready = 1;
    tick();
    bready = 0;
    check("b_done", {bvalid, awready, wready}, 3'b011);
    if (m_hit(a)) check("regs_o_wr", regs_o[a[5:2]*32 +: 32], m_regs[a[5:2]]);
  endtask
  task automatic axi_read(input logic [31:0] a, input int r_d);
    int cyc = 0;
    araddr = a; arvalid = 1;
    while (!arready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!arready) begin
      arvalid = 0;
      check("ar_timeout", 0, 1);
      return;
    end
    tick();
    arvalid = 0;
    check("r_latency", {rvalid, arready}, 2'b10);
    for (int k = 0; k < r_d; k++) begin
      check("r_hold", rdata, m_rd(a));
      check("r_hold_valid", rvalid, 1);
      tick();
    end
    check("rdata", rdata, m_rd(a));
    check("rresp", rresp, m_resp(a));
    rready = 1;
    tick();
    rready = 0;
    check("r_done", {rvalid, arready}, 2'b01);
  endtask
  initial begin
    logic [31:0] old, a;
    int idx;
    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
    repeat (3) tick();
    rst = 0;
    check("rst_ready", {awready, wready, arready}, 3'b111);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp", {bresp, rresp}, 4'b0);
    check("rst_rdata", rdata, 0);
    check_all_regs("rst_regs");
    for (int k = 0; k < NR; k++) axi_read(32'(k * 4), 0);
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    check("reg2_val", regs_o[2*32 +: 32], 32'hDEADBEEF);
    axi_read(32'h8, 1);
    axi_write(32'h4, 32'h11223344, 4'hF, 2, 0, 0);
    axi_write(32'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    check("reg1_strb", regs_o[1*32 +: 32], 32'h11BB33DD);
    axi_write(32'h10, 32'h12345678, 4'h0, 1, 1, 0);
    check("reg4_nostrb", regs_o[4*32 +: 32], 32'h0);
    axi_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    axi_write(32'hC, 32'hA5A50000, 4'hF, 0, 0, 0);
    old = m_regs[3];
    awaddr = 32'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; araddr = 32'hC; arvalid = 1;
    tick();
    arvalid = 0;
    check("rw_same_edge_rvalid", {rvalid, bvalid}, 2'b11);
    check("rw_same_edge_old", rdata, old);
    m_wr(32'hC, 32'h55, 4'hF);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    axi_read(32'hC, 0);
    axi_write(32'(NR * 4), 32'hFFFFFFFF, 4'hF, 0, 0, 1);
    axi_read(32'(NR * 4), 0);
    check_all_regs("oor_regs");
    for (int n = 0; n < 80; n++) begin
      idx = int'($urandom_range(0, NR + 2));
      a = idx == NR + 2 ? 32'hFFFFFF00 : 32'(idx * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        axi_read(a, int'($urandom_range(0, 2)));
    end
    check_all_regs("rand_regs");
    awaddr = 32'h0; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
    check("midrst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    tick();
    check("midrst_nob", bvalid, 0);
    check_all_regs("midrst_regs");
    axi_read(32'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
